i2c_target_rx: RTL and testbench



---
 rtl/i2c_target_rx.sv | 248 ++++++++++++++++++++++++
 tb/tb_i2c_target_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C target engine. Oversamples SCL/SDA on ref_clk, detects
// START/STOP, answers TARGET_ADDR, ACKs and receives write bytes, and shifts
// out read bytes supplied on tx_data. SDA is open-drain (sda_oe=1 pulls low).
// Optional build macro GLITCH_FILTER_EN adds a FILTER_LEN-sample glitch filter
// after the synchronizers.
module i2c_target_rx #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 4
) (
  input  logic       ref_clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       stop_det
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_check
    $error("i2c_target_rx: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_raw, sda_raw;
  logic                   scl_s, sda_s;
  logic                   scl_q, sda_q;
  logic                   scl_rise, scl_fall, start_c, stop_c;

  state_t     state;
  logic [2:0] cnt;
  logic       full;
  logic       rw;
  logic       ack_ok;
  logic [7:0] sr;
  logic [7:0] tx_sr;

  // Input synchronizers; idle bus level is high so they reset to 1.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
    end
  end

  assign scl_raw = scl_sync[SYNC_STAGES-1];
  assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic [FCW-1:0] scl_fcnt, sda_fcnt;

  // Each filtered line follows its input only after FILTER_LEN differing samples in a row.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s    <= 1'b1;
      sda_s    <= 1'b1;
      scl_fcnt <= '0;
      sda_fcnt <= '0;
    end else begin
      if (scl_raw == scl_s) begin
        scl_fcnt <= '0;
      end else if (scl_fcnt == FCW'(FILTER_LEN - 1)) begin
        scl_s    <= scl_raw;
        scl_fcnt <= '0;
      end else begin
        scl_fcnt <= scl_fcnt + 1'b1;
      end
      if (sda_raw == sda_s) begin
        sda_fcnt <= '0;
      end else if (sda_fcnt == FCW'(FILTER_LEN - 1)) begin
        sda_s    <= sda_raw;
        sda_fcnt <= '0;
      end else begin
        sda_fcnt <= sda_fcnt + 1'b1;
      end
    end
  end
`else
  assign scl_s = scl_raw;
  assign sda_s = sda_raw;
`endif

  // Previous sample of the conditioned lines for edge and START/STOP detection.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start_c  = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_c   = scl_s & scl_q & ~sda_q & sda_s;

  // Protocol FSM with registered outputs; STOP, then START, override any SCL edge.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      full     <= 1'b0;
      rw       <= 1'b0;
      ack_ok   <= 1'b0;
      sr       <= 8'h00;
      tx_sr    <= 8'h00;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      stop_det <= 1'b0;
      if (stop_c) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        stop_det <= 1'b1;
        cnt      <= 3'd0;
        full     <= 1'b0;
        ack_ok   <= 1'b0;
      end else if (start_c) begin
        state  <= ADDR;
        sda_oe <= 1'b0;
        cnt    <= 3'd0;
        full   <= 1'b0;
        ack_ok <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise && !full) begin
              sr <= {sr[6:0], sda_s};
              if (cnt == 3'd7) full <= 1'b1;
              else             cnt  <= cnt + 3'd1;
            end else if (scl_fall && full) begin
              full <= 1'b0;
              cnt  <= 3'd0;
              if (sr[7:1] == TARGET_ADDR) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= sr[0];
                tx_req <= sr[0];
                state  <= ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              cnt <= 3'd0;
              if (rw) begin
                tx_sr  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                full   <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && !full) begin
              sr <= {sr[6:0], sda_s};
              if (cnt == 3'd7) begin
                full     <= 1'b1;
                rx_data  <= {sr[6:0], sda_s};
                rx_valid <= 1'b1;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end else if (scl_fall && full) begin
              sda_oe <= 1'b1;
              full   <= 1'b0;
              cnt    <= 3'd0;
              state  <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 3'd0;
              state  <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (cnt == 3'd7) begin
                sda_oe <= 1'b0;
                cnt    <= 3'd0;
                ack_ok <= 1'b0;
                state  <= RD_ACK;
              end else begin
                cnt    <= cnt + 3'd1;
                tx_sr  <= {tx_sr[6:0], 1'b0};
                sda_oe <= ~tx_sr[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                ack_ok <= 1'b1;
                tx_req <= 1'b1;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end else if (scl_fall && ack_ok) begin
              tx_sr  <= tx_data;
              sda_oe <= ~tx_data[7];
              cnt    <= 3'd0;
              ack_ok <= 1'b0;
              state  <= RD_DATA;
            end
          end
          WAIT_STOP: begin
            busy   <= 1'b0;
            sda_oe <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx: a bus-level I2C master model drives directed and
// randomized transactions; expected ACKs, received bytes and read bits come from
// a transaction-level model of the target's behaviour.
module tb_i2c_target_rx;
  localparam int Q = 10;  // quarter SCL period in ref_clk cycles

  logic       ref_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       scl_m   = 1'b1;
  logic       sda_m   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       scl_in, sda_in;
  logic       sda_oe, rx_valid, tx_req, busy, stop_det;
  logic [7:0] rx_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_rx #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
    .ref_clk(ref_clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req),
    .tx_data(tx_data), .busy(busy), .stop_det(stop_det)
  );

  always #5 ref_clk = ~ref_clk;

  int vectors = 0;
  int miscompares = 0;
  int rx_cnt = 0, txr_cnt = 0, stop_cnt = 0, coinc = 0;
  logic [7:0] rx_q[$];

  // Bus-side monitor of the single-cycle output pulses.
  always @(negedge ref_clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_q.push_back(rx_data);
    end
    if (tx_req) txr_cnt++;
    if (stop_det) stop_cnt++;
    if (rx_valid && stop_det) coinc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge ref_clk);
  endtask

  task automatic do_start();
    if (!scl_m) begin
      sda_m = 1'b1; wt(Q);
      scl_m = 1'b1; wt(Q);
    end
    sda_m = 1'b0; wt(Q);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic do_stop();
    sda_m = 1'b0; wt(Q);
    scl_m = 1'b1; wt(Q);
    sda_m = 1'b1; wt(Q);
  endtask

  task automatic clk_bit(input logic b, input logic glitch, output logic sda_seen, output logic oe_mid);
    sda_m = b; wt(Q);
    scl_m = 1'b1; wt(Q / 2);
    if (glitch) begin
      scl_m = 1'b0; wt(2);
      scl_m = 1'b1;
    end
    wt(Q / 2);
    sda_seen = sda_in;
    oe_mid   = sda_oe;
    wt(Q);
    scl_m = 1'b0; wt(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s, o;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, s, o);
    clk_bit(1'b1, 1'b0, s, o);
    chk(tag, o, exp_ack);
  endtask

  task automatic read_byte(output logic [7:0] v, input logic nack, input logic [7:0] next_tx);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s, o);
      v[i] = s;
    end
    tx_data = next_tx;
    clk_bit(nack, 1'b0, s, o);
  endtask

  initial begin
    logic [7:0] v, d, nx;
    logic [6:0] a;
    logic       s, o, match, rd;
    int         r0, t0, p0, q0, nb;
    logic [7:0] exp_q[$];

    // Reset values
    wt(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stop_det", stop_det, 0);
    rst_n = 1'b1;
    wt(Q);

    // Write 0x50/W, 0xA5, 0x3C, STOP
    r0 = rx_cnt; q0 = rx_q.size(); p0 = stop_cnt;
    do_start();
    send_byte(8'hA0, 1'b1, "w1_addr_ack");
    chk("w1_busy_mid", busy, 1);
    send_byte(8'hA5, 1'b1, "w1_d0_ack");
    send_byte(8'h3C, 1'b1, "w1_d1_ack");
    do_stop();
    wt(Q);
    chk("w1_rx_cnt", rx_cnt - r0, 2);
    chk("w1_rx0", rx_q[q0], 8'hA5);
    chk("w1_rx1", rx_q[q0 + 1], 8'h3C);
    chk("w1_stop_cnt", stop_cnt - p0, 1);
    chk("w1_busy_end", busy, 0);

    // Wrong address 0x51/W, 0xFF
    r0 = rx_cnt; p0 = stop_cnt;
    do_start();
    send_byte(8'hA2, 1'b0, "na_addr_ack");
    chk("na_busy", busy, 0);
    send_byte(8'hFF, 1'b0, "na_d0_ack");
    do_stop();
    wt(Q);
    chk("na_rx_cnt", rx_cnt - r0, 0);
    chk("na_stop_cnt", stop_cnt - p0, 1);

    // Read 0x50/R: 0xC3 (ACK), 0x5A (NACK)
    t0 = txr_cnt; p0 = stop_cnt;
    tx_data = 8'hC3;
    do_start();
    send_byte(8'hA1, 1'b1, "rd_addr_ack");
    read_byte(v, 1'b0, 8'h5A);
    chk("rd_b0", v, 8'hC3);
    read_byte(v, 1'b1, 8'h00);
    chk("rd_b1", v, 8'h5A);
    chk("rd_released", sda_oe, 0);
    chk("rd_busy_nack", busy, 0);
    do_stop();
    wt(Q);
    chk("rd_tx_req_cnt", txr_cnt - t0, 2);
    chk("rd_stop_cnt", stop_cnt - p0, 1);

    // Write 0x12, repeated START, read with NACK
    t0 = txr_cnt; r0 = rx_cnt;
    do_start();
    send_byte(8'hA0, 1'b1, "rs_addr_w_ack");
    send_byte(8'h12, 1'b1, "rs_d0_ack");
    d = 8'($urandom);
    tx_data = d;
    do_start();
    send_byte(8'hA1, 1'b1, "rs_addr_r_ack");
    read_byte(v, 1'b1, 8'h00);
    chk("rs_rd_byte", v, d);
    do_stop();
    wt(Q);
    chk("rs_rx_data", rx_data, 8'h12);
    chk("rs_rx_cnt", rx_cnt - r0, 1);
    chk("rs_tx_req_cnt", txr_cnt - t0, 1);
    chk("rs_busy_end", busy, 0);

    // STOP after 4 bits of a write byte
    r0 = rx_cnt; p0 = stop_cnt;
    do_start();
    send_byte(8'hA0, 1'b1, "pt_addr_ack");
    for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, s, o);
    do_stop();
    wt(Q);
    chk("pt_rx_cnt", rx_cnt - r0, 0);
    chk("pt_stop_cnt", stop_cnt - p0, 1);

    // Reset asserted in the middle of the address ACK
    do_start();
    for (int i = 7; i >= 0; i--) clk_bit(i == 0 ? 1'b0 : (8'hA0 >> i) & 1'b1, 1'b0, s, o);
    sda_m = 1'b1; wt(Q);
    scl_m = 1'b1; wt(Q / 2);
    chk("rs_pre_ack", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_sda_oe_now", sda_oe, 0);
    chk("rs_busy_now", busy, 0);
    chk("rs_rx_data_now", rx_data, 0);
    wt(Q);
    rst_n = 1'b1;
    wt(Q);

    // Randomized transactions against a transaction-level model
    for (int t = 0; t < 12; t++) begin
      a     = ($urandom % 2) ? 7'h50 : 7'($urandom);
      match = (a == 7'h50);
      rd    = 1'($urandom);
      nb    = 1 + int'($urandom % 3);
      r0 = rx_cnt; q0 = rx_q.size(); t0 = txr_cnt; p0 = stop_cnt;
      exp_q.delete();
      d = 8'($urandom);
      tx_data = d;
      do_start();
      send_byte({a, rd}, match, "rnd_addr_ack");
      for (int k = 0; k < nb; k++) begin
        if (rd) begin
          nx = 8'($urandom);
          read_byte(v, (k == nb - 1), nx);
          chk("rnd_rd_byte", v, match ? d : 8'hFF);
          d = nx;
        end else begin
          d = 8'($urandom);
          send_byte(d, match, "rnd_wr_ack");
          if (match) exp_q.push_back(d);
        end
      end
      do_stop();
      wt(Q);
      chk("rnd_rx_cnt", rx_cnt - r0, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) chk("rnd_rx_byte", rx_q[q0 + k], exp_q[k]);
      chk("rnd_tx_req_cnt", txr_cnt - t0, (match && rd) ? nb : 0);
      chk("rnd_stop_cnt", stop_cnt - p0, 1);
      chk("rnd_busy_end", busy, 0);
    end

`ifdef GLITCH_FILTER_EN
    // Short SCL low glitch inside a write byte must not add a bit
    r0 = rx_cnt; q0 = rx_q.size();
    do_start();
    send_byte(8'hA0, 1'b1, "gf_addr_ack");
    for (int i = 7; i >= 0; i--) clk_bit((8'hA5 >> i) & 1'b1, (i == 5), s, o);
    clk_bit(1'b1, 1'b0, s, o);
    chk("gf_ack", o, 1);
    do_stop();
    wt(Q);
    chk("gf_rx_cnt", rx_cnt - r0, 1);
    chk("gf_rx_byte", rx_q[q0], 8'hA5);
`endif

    chk("no_rx_stop_coincide", coinc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
